proc_feeder: RTL and testbench

- Instruction-issue engine that drives the 9-bit processor's DIN/Run side of the Run/Done handshake.
- Fetches 9-bit words from a synchronous program ROM, presents each instruction with a one-cycle Run pulse, then presents the immediate word in the following cycle (mvi only).
- Waits for the processor's Done to rise and fall before issuing the next instruction.
- Sits between the program ROM and the processor core, replacing bench-driven DIN/Run.

---
 rtl/proc_pkg.sv | 27 ++
 rtl/proc_feeder.sv | 134 +++++++++++++
 tb/tb_proc_feeder.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/proc_pkg.sv
// Shared opcode encodings and feeder state type for the instruction-issue engine.
package proc_pkg;

  localparam int unsigned OPC_W = 3;

  localparam logic [OPC_W-1:0] OP_MV   = 3'b000;
  localparam logic [OPC_W-1:0] OP_MVI  = 3'b001;
  localparam logic [OPC_W-1:0] OP_ADD  = 3'b010;
  localparam logic [OPC_W-1:0] OP_SUB  = 3'b011;
  localparam logic [OPC_W-1:0] OP_LD   = 3'b100;
  localparam logic [OPC_W-1:0] OP_HALT = 3'b111;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    CAPT,
    IMM_ADDR,
    IMM_CAPT,
    ISSUE,
    OPERAND,
    WAIT_HI,
    WAIT_LO,
    HALTED,
    ERROR
  } feeder_state_t;

endpackage

// File: rtl/proc_feeder.sv
// Fetches words from a synchronous ROM and drives DIN/Run into the processor,
// pacing each instruction on the processor's Done rise/fall handshake.
module proc_feeder
  import proc_pkg::*;
#(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 9,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  output logic [ADDR_W-1:0] Mem_addr,
  input  logic [DATA_W-1:0] Mem_data,
  output logic [DATA_W-1:0] DIN,
  output logic              Run,
  input  logic              Done,
  output logic              Busy,
  output logic              Halted,
  output logic              Error,
  output logic [7:0]        Instr_count
);

  localparam int unsigned TMO_W   = $clog2(TIMEOUT + 1);
  localparam int unsigned OPC_LSB = DATA_W - OPC_W;

  feeder_state_t     state;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] imm;
  logic [TMO_W-1:0]  tmo;
  logic [OPC_W-1:0]  rom_opc;
  logic              ir_is_mvi;
  logic              tmo_last;

  assign Mem_addr  = pc;
  assign rom_opc   = Mem_data[DATA_W-1:OPC_LSB];
  assign ir_is_mvi = (ir[DATA_W-1:OPC_LSB] == OP_MVI);
  assign tmo_last  = (tmo == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      pc          <= '0;
      ir          <= '0;
      imm         <= '0;
      tmo         <= '0;
      DIN         <= '0;
      Run         <= 1'b0;
      Busy        <= 1'b0;
      Halted      <= 1'b0;
      Error       <= 1'b0;
      Instr_count <= '0;
    end else begin
      case (state)
        IDLE, HALTED, ERROR: begin
          if (Start) begin
            state       <= FETCH;
            pc          <= '0;
            Instr_count <= '0;
            Busy        <= 1'b1;
            Halted      <= 1'b0;
            Error       <= 1'b0;
          end
        end
        FETCH: state <= CAPT;
        CAPT: begin
          ir <= Mem_data;
          pc <= pc + ADDR_W'(1);
          if (rom_opc == OP_HALT) begin
            state  <= HALTED;
            Halted <= 1'b1;
            Busy   <= 1'b0;
          end else if (rom_opc == OP_MVI) begin
            state <= IMM_ADDR;
          end else begin
            state <= ISSUE;
            DIN   <= Mem_data;
            Run   <= 1'b1;
          end
        end
        IMM_ADDR: state <= IMM_CAPT;
        IMM_CAPT: begin
          imm   <= Mem_data;
          pc    <= pc + ADDR_W'(1);
          state <= ISSUE;
          DIN   <= ir;
          Run   <= 1'b1;
        end
        ISSUE: begin
          state <= OPERAND;
          Run   <= 1'b0;
          DIN   <= ir_is_mvi ? imm : '0;
        end
        // Done may already be high here for single-cycle instructions
        OPERAND: begin
          tmo <= '0;
          if (Done) begin
            state <= WAIT_LO;
            DIN   <= '0;
          end else begin
            state <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          tmo <= tmo + TMO_W'(1);
          if (Done) begin
            state <= WAIT_LO;
            DIN   <= '0;
          end else if (tmo_last) begin
            state <= ERROR;
            Error <= 1'b1;
            Busy  <= 1'b0;
            DIN   <= '0;
          end
        end
        WAIT_LO: begin
          tmo <= tmo + TMO_W'(1);
          if (!Done) begin
            state       <= FETCH;
            Instr_count <= Instr_count + 8'd1;
          end else if (tmo_last) begin
            state <= ERROR;
            Error <= 1'b1;
            Busy  <= 1'b0;
            DIN   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_feeder.sv
// Randomized scoreboard bench for proc_feeder with a ROM model and a Done responder.
module tb_proc_feeder;
  import proc_pkg::*;

  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 9;
  localparam int unsigned TMO   = 16;
  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [DW-1:0] HALT_W = 9'h1C0;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          Start;
  logic          Done;
  logic [AW-1:0] Mem_addr;
  logic [DW-1:0] Mem_data;
  logic [DW-1:0] DIN;
  logic          Run, Busy, Halted, Error;
  logic [7:0]    Instr_count;

  always #5 Clock = ~Clock;

  logic [DW-1:0] rom [DEPTH];
  always @(posedge Clock) Mem_data <= rom[Mem_addr];

  proc_feeder #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Mem_addr(Mem_addr),
    .Mem_data(Mem_data), .DIN(DIN), .Run(Run), .Done(Done), .Busy(Busy),
    .Halted(Halted), .Error(Error), .Instr_count(Instr_count)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] instr;
    logic [DW-1:0] oper;
  } exp_t;
  exp_t sb[$];
  exp_t cur;
  logic pend = 1'b0;
  int   run_cyc[$];
  int   dmode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every Run pulse pops one expected instruction; the following cycle checks the operand
  always @(negedge Clock) begin
    if (pend) begin
      check("run_single_cycle", 32'(Run), 32'd0);
      check("operand_din", 32'(DIN), 32'(cur.oper));
      pend = 1'b0;
    end
    if (Run === 1'b1) begin
      run_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_issue: DIN=%0h with no expected instruction", DIN);
      end else begin
        cur = sb.pop_front();
        check("issue_din", 32'(DIN), 32'(cur.instr));
        pend = 1'b1;
      end
    end
  end

  // Processor Done model: 0 random, 1/2 fixed rise delay, 3 never responds
  initial begin
    Done = 1'b0;
    forever begin
      @(negedge Clock);
      if (Run === 1'b1 && dmode != 3) begin
        int d, h;
        d = (dmode == 0) ? int'($urandom_range(1, 4)) : dmode;
        h = (dmode == 0) ? int'($urandom_range(1, 3)) : 1;
        repeat (d) @(negedge Clock);
        Done = 1'b1;
        repeat (h) @(negedge Clock);
        Done = 1'b0;
      end
    end
  end

  // Reference: walk the program as the processor would see it
  task automatic run_model(input int max_issues, output int n, output int pc_o);
    int pc;
    logic [DW-1:0] w, imm;
    exp_t e;
    pc = 0;
    n = 0;
    while (n < max_issues) begin
      w  = rom[pc];
      pc = (pc + 1) % DEPTH;
      if (w[8:6] == OP_HALT) break;
      if (w[8:6] == OP_MVI) begin
        imm = rom[pc];
        pc  = (pc + 1) % DEPTH;
      end else begin
        imm = '0;
      end
      e.instr = w;
      e.oper  = imm;
      sb.push_back(e);
      n++;
    end
    pc_o = pc;
  endtask

  task automatic push_exp(input logic [DW-1:0] i, input logic [DW-1:0] o);
    exp_t e;
    e.instr = i;
    e.oper  = o;
    sb.push_back(e);
  endtask

  task automatic fill_halt();
    for (int i = 0; i < int'(DEPTH); i++) rom[i] = HALT_W;
  endtask

  task automatic pulse_start();
    @(negedge Clock);
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  task automatic finish_prog(input string name, input int exp_cnt, input int exp_addr);
    int n;
    n = 0;
    while (Halted !== 1'b1 && Error !== 1'b1 && n < 800) begin
      @(negedge Clock);
      n++;
    end
    check({name, "_halted"}, 32'(Halted), 32'd1);
    check({name, "_count"}, 32'(Instr_count), 32'(exp_cnt));
    check({name, "_addr"}, 32'(Mem_addr), 32'(exp_addr));
    check({name, "_busy"}, 32'(Busy), 32'd0);
    check({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, pc_o, k;
    Reset = 1'b1;
    Start = 1'b0;
    fill_halt();
    repeat (3) @(negedge Clock);
    check("rst_state", 32'(dut.state), 32'(IDLE));
    check("rst_run", 32'(Run), 32'd0);
    check("rst_din", 32'(DIN), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_halted", 32'(Halted), 32'd0);
    check("rst_error", 32'(Error), 32'd0);
    check("rst_count", 32'(Instr_count), 32'd0);
    check("rst_addr", 32'(Mem_addr), 32'd0);
    Reset = 1'b0;

    // mvi followed by halt
    dmode = 2;
    fill_halt();
    rom[0] = 9'h040; rom[1] = 9'h007; rom[2] = 9'h1C0;
    push_exp(9'h040, 9'h007);
    pulse_start();
    finish_prog("mvi_halt", 1, 3);

    // two non-immediate instructions, restarted from HALTED
    fill_halt();
    rom[0] = 9'h0C1; rom[1] = 9'h020; rom[2] = {3'b111, 6'($urandom)};
    push_exp(9'h0C1, 9'h000);
    push_exp(9'h020, 9'h000);
    pulse_start();
    check("restart_busy", 32'(Busy), 32'd1);
    finish_prog("sub_mv", 2, 3);

    // Done never arrives -> timeout, then Start recovers
    dmode = 3;
    fill_halt();
    rom[0] = 9'h005;
    push_exp(9'h005, 9'h000);
    pulse_start();
    n = 0;
    while (dut.state != WAIT_HI && n < 50) begin
      @(negedge Clock);
      n++;
    end
    check("reach_wait_hi", 32'(dut.state), 32'(WAIT_HI));
    n = 0;
    while (Error !== 1'b1 && n < 40) begin
      @(negedge Clock);
      n++;
    end
    check("timeout_cycles", 32'(n), 32'(TMO));
    check("err_state", 32'(dut.state), 32'(ERROR));
    check("err_run", 32'(Run), 32'd0);
    check("err_din", 32'(DIN), 32'd0);
    check("err_busy", 32'(Busy), 32'd0);
    check("err_count", 32'(Instr_count), 32'd0);
    dmode = 2;
    push_exp(9'h005, 9'h000);
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    check("recover_error", 32'(Error), 32'd0);
    check("recover_state", 32'(dut.state), 32'(FETCH));
    check("recover_addr", 32'(Mem_addr), 32'd0);
    finish_prog("recover", 1, 2);

    // Done high in OPERAND, low next cycle: minimum 5-cycle cadence
    dmode = 1;
    fill_halt();
    rom[0] = 9'h00A; rom[1] = 9'h0D3;
    push_exp(9'h00A, 9'h000);
    push_exp(9'h0D3, 9'h000);
    run_cyc.delete();
    pulse_start();
    finish_prog("fast_done", 2, 3);
    check("fast_issues", 32'(run_cyc.size()), 32'd2);
    if (run_cyc.size() == 2) check("fast_cadence", 32'(run_cyc[1] - run_cyc[0]), 32'd5);

    // random programs terminated by HALT
    dmode = 0;
    for (int t = 0; t < 4; t++) begin
      fill_halt();
      k = int'($urandom_range(3, 12));
      for (int i = 0; i < k; i++) rom[i] = {3'($urandom_range(0, 6)), 6'($urandom)};
      run_model(100, n, pc_o);
      pulse_start();
      finish_prog("rand_prog", n, pc_o);
    end

    // circular program with mvi at the last address; Start pulses while busy
    for (int i = 0; i < int'(DEPTH) - 1; i++) begin
      k = int'($urandom_range(0, 5));
      rom[i] = {3'((k == 0) ? 0 : k + 1), 6'($urandom)};
    end
    rom[DEPTH-1] = {OP_MVI, 6'($urandom)};
    run_model(80, n, pc_o);
    pulse_start();
    n = 0;
    while (Instr_count != 8'd40 && n < 3000) begin
      @(negedge Clock);
      Start = ($urandom_range(0, 5) == 0);
      n++;
    end
    Start = 1'b0;
    check("wrap_count", 32'(Instr_count), 32'd40);
    check("wrap_busy", 32'(Busy), 32'd1);
    check("wrap_no_halt", 32'(Halted), 32'd0);
    while (Run === 1'b1) @(negedge Clock);
    #2 Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    repeat (10) @(negedge Clock);
    sb.delete();

    // reset in the middle of ISSUE
    fill_halt();
    rom[0] = 9'h011;
    push_exp(9'h011, 9'h000);
    pulse_start();
    n = 0;
    while (Run !== 1'b1 && n < 20) begin
      @(negedge Clock);
      n++;
    end
    check("pre_reset_run", 32'(Run), 32'd1);
    #2 Reset = 1'b1;
    @(negedge Clock);
    check("midrst_run", 32'(Run), 32'd0);
    check("midrst_din", 32'(DIN), 32'd0);
    check("midrst_busy", 32'(Busy), 32'd0);
    check("midrst_state", 32'(dut.state), 32'(IDLE));
    check("midrst_addr", 32'(Mem_addr), 32'd0);
    Reset = 1'b0;
    repeat (10) @(negedge Clock);
    check("midrst_idle", 32'(dut.state), 32'(IDLE));
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
